// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and constants for the UART receive path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Receive controller states
  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_LISTEN   = 3'd1,
    ST_WRITE    = 3'd2,
    ST_RETX     = 3'd3,
    ST_ABORT    = 3'd4
  } rx_ctrl_state_t;

  // Consecutive failed frames tolerated before a byte is abandoned
  localparam int DEF_MAX_RETRY = 3;

  // Receiver oversampling ratio (ticks per bit)
  localparam int OVS = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divider producing a one-cycle oversample strobe every div+1 clocks while enabled.
// Latency: first tick div+1 clocks after en rises; counter and tick held at 0 while en is low.
// Backpressure: none; free-running strobe, no handshake.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  // Count clocks up to div; >= keeps a mid-run decrease of div from overshooting a full wrap
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt >= div) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversample strobe, commit of good bytes to the RX FIFO, bounded retransmit sequencing, status counters.
// Latency: flag rise -> FIFO write next cycle; fb rise -> retx_req next cycle; retx_ack -> retx_req low next cycle.
// Backpressure: fifo_full at commit drops the byte and sets overrun; retx_req is held until retx_ack.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             rx_en,
  input  logic [DIV_W-1:0] baud_div,
  output logic             rx_tick,
  input  logic [7:0]       rcv_dout,
  input  logic             rcv_flag,
  input  logic             rcv_fb,
  input  logic             fifo_full,
  output logic             fifo_wr,
  output logic [7:0]       fifo_wdata,
  output logic             retx_req,
  input  logic             retx_ack,
  input  logic             clr_status,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       err_cnt,
  output logic             overrun,
  output logic             abort,
  output logic             drop
);

  // Retry threshold narrowed to the retry counter width (MAX_RETRY is 1..15)
  localparam logic [3:0] MAX_RETRY_L = 4'(MAX_RETRY);

  rx_ctrl_state_t state;
  logic           flag_q;
  logic           fb_q;
  logic           flag_rise;
  logic           fb_rise;
  logic [3:0]     retry_cnt;
  logic [3:0]     retry_nxt;
  logic [7:0]     data_q;

  assign flag_rise = rcv_flag & ~flag_q;
  assign fb_rise   = rcv_fb & ~fb_q;
  assign retry_nxt = retry_cnt + 4'd1;

  // Strobes toward FIFO and transmitter are pure state decodes so a reset kills them immediately
  assign fifo_wr    = (state == ST_WRITE);
  assign retx_req   = (state == ST_RETX);
  assign drop       = (state == ST_ABORT);
  assign fifo_wdata = data_q;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clk      (clk),
    .areset_n (areset_n),
    .en       (state != ST_DISABLED),
    .div      (baud_div),
    .tick     (rx_tick)
  );

  // Delay receiver levels by one cycle for rise detection
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      flag_q <= 1'b0;
      fb_q   <= 1'b0;
    end else begin
      flag_q <= rcv_flag;
      fb_q   <= rcv_fb;
    end
  end

  // Controller FSM with retry tracking, data capture and status counters
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= ST_DISABLED;
      retry_cnt <= '0;
      data_q    <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      overrun   <= 1'b0;
      abort     <= 1'b0;
    end else begin
      case (state)
        ST_DISABLED: begin
          retry_cnt <= '0;
          if (rx_en) begin
            state <= ST_LISTEN;
          end
        end

        ST_LISTEN: begin
          if (!rx_en) begin
            state     <= ST_DISABLED;
            retry_cnt <= '0;
          end else if (fb_rise) begin
            // A retransmit request beats a same-cycle good-frame indication
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
            retry_cnt <= retry_nxt;
            if (retry_nxt < MAX_RETRY_L) begin
              state <= ST_RETX;
            end else begin
              state <= ST_ABORT;
            end
          end else if (flag_rise) begin
            if (fifo_full) begin
              overrun <= 1'b1;
            end else begin
              data_q <= rcv_dout;
              state  <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          // The single write always completes, even if rx_en just dropped
          if (frame_cnt != {CNT_W{1'b1}}) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
          retry_cnt <= '0;
          if (flag_rise) begin
            overrun <= 1'b1;
          end
          if (rx_en) begin
            state <= ST_LISTEN;
          end else begin
            state <= ST_DISABLED;
          end
        end

        ST_RETX: begin
          if (flag_rise) begin
            overrun <= 1'b1;
          end
          if (!rx_en) begin
            state     <= ST_DISABLED;
            retry_cnt <= '0;
          end else if (retx_ack) begin
            state <= ST_LISTEN;
          end
        end

        ST_ABORT: begin
          abort     <= 1'b1;
          retry_cnt <= '0;
          if (flag_rise) begin
            overrun <= 1'b1;
          end
          if (rx_en) begin
            state <= ST_LISTEN;
          end else begin
            state <= ST_DISABLED;
          end
        end

        default: begin
          state     <= ST_DISABLED;
          retry_cnt <= '0;
        end
      endcase

      // Status clear overrides any increment or set in the same cycle
      if (clr_status) begin
        frame_cnt <= '0;
        err_cnt   <= '0;
        overrun   <= 1'b0;
        abort     <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver. Generates the 16x oversampling strobe that clocks the receiver. Monitors the receiver's `flag` and `fb` outputs. Commits good bytes to the RX FIFO. Sequences retransmit requests toward the transmitter with a bounded retry count. Sits between the receiver, the RX FIFO and the transmitter's retransmit input, and exports status counters.

## Interface
- `DIV_W`, 16, width of the oversample divider
- `MAX_RETRY`, 3, consecutive failed frames allowed before a byte is abandoned (range 1..15)
- `CNT_W`, 16, width of `frame_cnt`
- `clk` in 1: single system clock
- `areset_n` in 1: reset, asynchronous and active-low
- `rx_en` in 1: enable reception
- `baud_div` in DIV_W: clocks per oversample tick minus 1
- `rx_tick` out 1: one-cycle oversample strobe to the receiver
- `rcv_dout` in 8: receiver data byte
- `rcv_flag` in 1: receiver frame-good level
- `rcv_fb` in 1: receiver retransmit-request level
- `fifo_full` in 1: RX FIFO full
- `fifo_wr` out 1: RX FIFO write strobe
- `fifo_wdata` out 8: RX FIFO write data
- `retx_req` out 1: retransmit request to the transmitter, held until acknowledged
- `retx_ack` in 1: transmitter acknowledge
- `clr_status` in 1: synchronous clear of the status outputs
- `frame_cnt` out CNT_W: good bytes written, saturating
- `err_cnt` out 8: bad frames seen, saturating
- `overrun` out 1: sticky, a good byte was lost
- `abort` out 1: sticky, a byte was abandoned after MAX_RETRY failures
- `drop` out 1: one-cycle pulse when a byte is abandoned

## Operation
- Reset: state DISABLED. All outputs, `div_cnt`, `retry_cnt`, the data register and the edge registers are 0.
- Edge detect: `rcv_flag` and `rcv_fb` are each registered. A rise is `in & ~in_q`. Rises are only acted on in LISTEN.
- Tick generator:
  - `div_cnt` is held at 0 in DISABLED.
  - Otherwise it increments each clock. When `div_cnt >= baud_div`, `rx_tick` = 1 and `div_cnt` returns to 0.
  - `baud_div` = 0 gives a tick every clock.
  - `>=` makes a mid-run decrease of `baud_div` safe.
- FSM states:
  - DISABLED: `rx_en` = 1 → LISTEN.
  - LISTEN:
    - If both rises occur in the same cycle, the fb rise wins.
    - fb rise: `err_cnt`++ and `retry_cnt`++. If the new `retry_cnt` < MAX_RETRY → RETX, else → ABORT.
    - flag rise with `fifo_full` = 1: set `overrun`, stay in LISTEN.
    - flag rise with `fifo_full` = 0: latch `rcv_dout` into the data register, → WRITE.
  - WRITE: `fifo_wr` = 1 for exactly one cycle. `frame_cnt`++, `retry_cnt` ← 0. → LISTEN.
  - RETX: `retx_req` = 1 until `retx_ack` is sampled high, then → LISTEN with `retx_req` low. Ticks continue.
  - ABORT: `drop` = 1 for one cycle, `abort` set, `retry_cnt` ← 0. → LISTEN.
- `rx_en` = 0 in any state → DISABLED on the next edge.
  - A WRITE in progress still completes its single write.
  - `retx_req` deasserts in the same transition.
  - `retry_cnt` ← 0.
- Rises arriving in WRITE, RETX or ABORT are not acted on. A flag rise in these states sets `overrun`.
- `clr_status` clears `frame_cnt`, `err_cnt`, `overrun` and `abort`. It wins over a same-cycle increment or set.
- Counters saturate at all-ones.

## Timing
- Flag rise at cycle N → WRITE in N+1 → `fifo_wr` and `fifo_wdata` valid in N+1 → `frame_cnt` updated at N+2.
- fb rise at N → `retx_req` high from N+1. If `retx_ack` is high at cycle M, `retx_req` is low from M+1.
- First `rx_tick` comes `baud_div`+1 cycles after entering LISTEN. Period is `baud_div`+1.
- `areset_n` assertion takes effect immediately, mid-frame included. No FIFO write or request survives it.
- All outputs are registered except `fifo_wr`, `retx_req` and `drop`, which are decoded from state.

## Structure
- The shared package `uart_pkg` holds:
  - the state encoding `rx_ctrl_state_t` (DISABLED, LISTEN, WRITE, RETX, ABORT)
  - `DEF_MAX_RETRY`
  - the oversample constant `OVS` = 16
- One sub-module: `uart_baud_tick`, holding the divider counter and `rx_tick`, with ports `clk`, `areset_n`, `en` and `div`.

## Test plan
- `baud_div` = 4, `rx_en` = 1 → `rx_tick` every 5 clocks. First tick 5 clocks after enable. `rx_en` = 0 → no ticks.
- `rcv_flag` rise with `rcv_dout` = 8'hA5 and `fifo_full` = 0 → `fifo_wr` is a one-cycle pulse one cycle later with data A5, and `frame_cnt` = 1.
- Same byte with `fifo_full` = 1 → no `fifo_wr`, `overrun` = 1, `frame_cnt` unchanged.
- Two fb rises with `retx_ack` returned 3 cycles after each `retx_req`, then a flag rise → two requests, `err_cnt` = 2, the byte is written, and `retry_cnt` is back to 0.
- Three consecutive fb rises with MAX_RETRY = 3 → two RETX episodes, then one `drop` pulse with `abort` = 1 and `err_cnt` = 3.
- `areset_n` pulled low while `retx_req` = 1 → all outputs return to 0 at once.
- `clr_status` pulsed in the same cycle as a WRITE → `frame_cnt` = 0.
